// File: rtl/seq_mul_if.sv
// Operand/result bundle for the sequential multiplier.
// The master issues operands and start; the slave answers with busy/done/out.
interface seq_mul_if #(
  parameter int N_BITS = 32
);
  logic [N_BITS-1:0]   in_a;
  logic [N_BITS-1:0]   in_b;
  logic                signed_mode;
  logic                start;
  logic                busy;
  logic                done;
  logic [2*N_BITS-1:0] out;

  modport master (
    output in_a, in_b, signed_mode, start,
    input  busy, done, out
  );

  modport slave (
    input  in_a, in_b, signed_mode, start,
    output busy, done, out
  );
endinterface

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// Operands are reduced to magnitudes on acceptance, the magnitude product is
// built BITS_PER_CYCLE multiplier bits per clock, and the sign is applied in
// one final cycle. Latency from the accepting edge to done is STEPS+1 clocks.
module seq_mul #(
  parameter int N_BITS         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic    clk,
  input logic    rst,
  seq_mul_if.slave bus
);

  localparam int STEPS = N_BITS / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                busy;

  logic [2*N_BITS-1:0] mcand;
  logic [2*N_BITS-1:0] acc;
  logic [2*N_BITS-1:0] acc_sum;
  logic [2*N_BITS-1:0] out_r;
  logic [N_BITS-1:0]   mplier;
  logic [N_BITS-1:0]   mag_a;
  logic [N_BITS-1:0]   mag_b;
  logic [CW-1:0]       cnt;
  logic                neg;
  logic                done_r;

  assign bus.busy = busy;
  assign bus.done = done_r;
  assign bus.out  = out_r;

  // Operand magnitudes; the most negative value maps to 2^(N-1), which fits unsigned.
  always_comb begin
    mag_a = bus.in_a;
    mag_b = bus.in_b;
    if (bus.signed_mode && bus.in_a[N_BITS-1]) mag_a = ~bus.in_a + 1'b1;
    if (bus.signed_mode && bus.in_b[N_BITS-1]) mag_b = ~bus.in_b + 1'b1;
  end

  // Partial-product sum for the multiplier bits retired this cycle.
  always_comb begin
    acc_sum = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) acc_sum = acc_sum + (mcand << i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; starts seen while busy simply fall through unused.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, shift-add during CALC, sign-correct and publish in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{N_BITS{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= CW'(STEPS);
            neg    <= bus.signed_mode & (bus.in_a[N_BITS-1] ^ bus.in_b[N_BITS-1]);
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt - 1'b1;
        end
        FIX: begin
          out_r  <= neg ? (~acc + 1'b1) : acc;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at N_BITS=8: stimulus pushes the expected
// product and completion cycle, a negedge monitor pops and compares on done.
// Two extra instances cover BITS_PER_CYCLE = 2 and 4.
module tb_seq_mul;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_if #(.N_BITS(N)) bus1 ();
  seq_mul_if #(.N_BITS(N)) bus2 ();
  seq_mul_if #(.N_BITS(N)) bus4 ();

  seq_mul #(.N_BITS(N), .BITS_PER_CYCLE(1)) dut    (.clk(clk), .rst(rst), .bus(bus1));
  seq_mul #(.N_BITS(N), .BITS_PER_CYCLE(2)) dut_k2 (.clk(clk), .rst(rst), .bus(bus2));
  seq_mul #(.N_BITS(N), .BITS_PER_CYCLE(4)) dut_k4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [15:0] prod;
    int          when;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference product used for the random vectors.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [15:0] p;
    if (sm) p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    else    p = {8'h00, a} * {8'h00, b};
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.done === 1'b1) begin
      checkOutput("busy_with_done", {31'b0, bus1.busy}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: done at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_out"}, {16'b0, bus1.out}, {16'b0, e.prod});
        checkOutput({e.name, "_cycle"}, cyc, e.when);
      end
    end
  end

  // Issue one start pulse at the current negedge; accepted at the next rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sm,
                               input logic [15:0] prod, input string name, input bit push);
    exp_t e;
    bus1.in_a        = a;
    bus1.in_b        = b;
    bus1.signed_mode = sm;
    bus1.start       = 1'b1;
    if (push) begin
      e.prod = prod;
      e.when = cyc + 1 + 9;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    bus1.start       = 1'b0;
    bus1.in_a        = 8'($urandom);
    bus1.in_b        = 8'($urandom);
    bus1.signed_mode = 1'($urandom);
  endtask

  // One full operation, returning at the done cycle so the next start lands there.
  task automatic runOne(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] prod, input string name);
    applyStimulus(a, b, sm, prod, name, 1'b1);
    repeat (9) @(negedge clk);
  endtask

  // Single operation on the K=2 or K=4 instance with a bounded latency count.
  task automatic runAlt(input int which, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] prod, input int lat, input string name);
    int n;
    logic dn;
    if (which == 2) begin
      bus2.in_a = a; bus2.in_b = b; bus2.signed_mode = sm; bus2.start = 1'b1;
    end else begin
      bus4.in_a = a; bus4.in_b = b; bus4.signed_mode = sm; bus4.start = 1'b1;
    end
    @(negedge clk);
    bus2.start = 1'b0;
    bus4.start = 1'b0;
    n = 0;
    dn = 1'b0;
    while (!dn && n < 20) begin
      @(negedge clk);
      n++;
      dn = (which == 2) ? bus2.done : bus4.done;
    end
    checkOutput({name, "_latency"}, n, lat);
    checkOutput({name, "_out"}, {16'b0, (which == 2) ? bus2.out : bus4.out}, {16'b0, prod});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rs;

    rst = 1'b1;
    bus1.in_a = '0; bus1.in_b = '0; bus1.signed_mode = 1'b0; bus1.start = 1'b0;
    bus2.in_a = '0; bus2.in_b = '0; bus2.signed_mode = 1'b0; bus2.start = 1'b0;
    bus4.in_a = '0; bus4.in_b = '0; bus4.signed_mode = 1'b0; bus4.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, bus1.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, bus1.done}, 32'd0);
    checkOutput("reset_out", {16'b0, bus1.out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned corner with explicit busy/done timing.
    applyStimulus(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255", 1'b1);
    checkOutput("busy_after_accept", {31'b0, bus1.busy}, 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("busy_in_fix", {31'b0, bus1.busy}, 32'd1);
    @(negedge clk);
    checkOutput("busy_dropped", {31'b0, bus1.busy}, 32'd0);
    checkOutput("done_raised", {31'b0, bus1.done}, 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'b0, bus1.done}, 32'd0);
    checkOutput("out_held", {16'b0, bus1.out}, 32'h0000FE01);

    // Signed and unsigned directed vectors, issued back-to-back from the done cycle.
    runOne(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    runOne(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
    runOne(8'h00, 8'hFF, 1'b1, 16'h0000, "s_0xm1");
    runOne(8'h05, 8'hFD, 1'b1, 16'hFFF1, "s_5xm3");
    runOne(8'h05, 8'hFD, 1'b0, 16'h04F1, "u_5x253");
    runOne(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1xm1");
    runOne(8'hC8, 8'h03, 1'b0, 16'h0258, "u_200x3");

    // Start pulsed mid-operation with other operands must be ignored.
    applyStimulus(8'h0C, 8'h0B, 1'b0, 16'h0084, "u_12x11_ignore", 1'b1);
    repeat (3) @(negedge clk);
    bus1.in_a = 8'd99; bus1.in_b = 8'd77; bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (5) @(negedge clk);

    // Start held high: each accept takes the operands present on its edge.
    bus1.in_a = 8'hC8; bus1.in_b = 8'h03; bus1.signed_mode = 1'b0; bus1.start = 1'b1;
    sb.push_back('{16'h0258, cyc + 10, "held0"});
    @(negedge clk);
    bus1.in_a = 8'($urandom); bus1.in_b = 8'($urandom); bus1.signed_mode = 1'($urandom);
    repeat (9) @(negedge clk);
    bus1.in_a = 8'h9C; bus1.in_b = 8'h64; bus1.signed_mode = 1'b1;
    sb.push_back('{16'hD8F0, cyc + 10, "held1"});
    @(negedge clk);
    bus1.in_a = 8'($urandom); bus1.in_b = 8'($urandom); bus1.signed_mode = 1'($urandom);
    repeat (9) @(negedge clk);
    bus1.in_a = 8'h11; bus1.in_b = 8'h0F; bus1.signed_mode = 1'b0;
    sb.push_back('{16'h00FF, cyc + 10, "held2"});
    @(negedge clk);
    bus1.in_a = 8'($urandom); bus1.in_b = 8'($urandom); bus1.signed_mode = 1'($urandom);
    repeat (9) @(negedge clk);
    bus1.in_a = 8'h7F; bus1.in_b = 8'h7F; bus1.signed_mode = 1'b1;
    sb.push_back('{16'h3F01, cyc + 10, "held3"});
    @(negedge clk);
    bus1.in_a = 8'($urandom); bus1.in_b = 8'($urandom); bus1.signed_mode = 1'($urandom);
    repeat (9) @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);

    // Reset during CALC aborts silently, ignoring a simultaneous start.
    applyStimulus(8'h55, 8'h66, 1'b0, 16'h0000, "aborted", 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'b0, bus1.busy}, 32'd0);
    checkOutput("abort_done", {31'b0, bus1.done}, 32'd0);
    checkOutput("abort_out", {16'b0, bus1.out}, 32'd0);
    rst = 1'b0;
    bus1.start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_still_idle", {31'b0, bus1.busy}, 32'd0);
    runOne(8'h0F, 8'hF1, 1'b1, 16'hFF1F, "s_15xm15_after_rst");
    @(negedge clk);

    // Random operand pairs against the reference model.
    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      runOne(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", k));
    end
    @(negedge clk);

    // Wider digit widths.
    runAlt(2, 8'hC8, 8'h03, 1'b0, 16'h0258, 5, "k2_200x3");
    runAlt(2, 8'h05, 8'hFD, 1'b1, 16'hFFF1, 5, "k2_5xm3");
    runAlt(4, 8'hC8, 8'h03, 1'b0, 16'h0258, 3, "k4_200x3");
    runAlt(4, 8'h80, 8'h80, 1'b1, 16'h4000, 3, "k4_m128xm128");

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
